// File: rtl/major_state_seq.sv
// Fetch/Defer/Execute major-state sequencer with run/halt/single-step control.
// Each major state lasts PHASES cycles. The next state is decoded from busIR in the last phase.
module major_state_seq #(
  parameter int PHASES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       run,
  input  logic                       step,
  input  logic [11:0]                busIR,
  output logic                       stateFetch,
  output logic                       stateDefer,
  output logic                       stateExec,
  output logic [$clog2(PHASES)-1:0]  phase,
  output logic                       ckFetch,
  output logic                       ckDefer,
  output logic                       ckExec,
  output logic                       instDone,
  output logic                       running
);

  localparam int PW = $clog2(PHASES);
  localparam logic [PW-1:0] LAST_PHASE = PW'(PHASES - 1);
  localparam logic [PW-1:0] STROBE_PHASE = PW'(1);

  typedef enum logic [1:0] {
    ST_HALT,
    ST_FETCH,
    ST_DEFER,
    ST_EXEC
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_next;
  logic            r_step_d;
  logic            r_single;
  logic            w_single_next;
  logic            w_complete;
  logic [2:0]      w_op;
  logic            w_ind;
  logic            w_unused;

  assign w_op     = busIR[11:9];
  assign w_ind    = busIR[8];
  assign w_unused = ^busIR[7:0];
  assign phase    = r_phase;

  always_comb begin
    w_state_next  = r_state;
    w_phase_next  = r_phase;
    w_single_next = r_single;
    w_complete    = 1'b0;
    case (r_state)
      ST_HALT: begin
        w_phase_next = '0;
        if (run) begin
          w_state_next  = ST_FETCH;
          w_single_next = 1'b0;
        end else if (step && !r_step_d) begin
          w_state_next  = ST_FETCH;
          w_single_next = 1'b1;
        end
      end
      ST_FETCH, ST_DEFER, ST_EXEC: begin
        if (r_phase == LAST_PHASE) begin
          w_phase_next = '0;
          if (r_state == ST_FETCH) begin
            // IOT/OPR never defer; JMP direct finishes in FETCH.
            if (w_op >= 3'd6)      w_complete   = 1'b1;
            else if (w_ind)        w_state_next = ST_DEFER;
            else if (w_op == 3'd5) w_complete   = 1'b1;
            else                   w_state_next = ST_EXEC;
          end else if (r_state == ST_DEFER) begin
            if (w_op <= 3'd4) w_state_next = ST_EXEC;
            else              w_complete   = 1'b1;
          end else begin
            w_complete = 1'b1;
          end
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_HALT;
        w_phase_next = '0;
      end
    endcase
    if (w_complete) begin
      w_single_next = 1'b0;
      w_state_next  = (run && !r_single) ? ST_FETCH : ST_HALT;
    end
  end

  // Outputs are registered from the next-state values, so they align with r_state/r_phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= ST_HALT;
      r_phase    <= '0;
      r_step_d   <= 1'b0;
      r_single   <= 1'b0;
      stateFetch <= 1'b0;
      stateDefer <= 1'b0;
      stateExec  <= 1'b0;
      ckFetch    <= 1'b0;
      ckDefer    <= 1'b0;
      ckExec     <= 1'b0;
      instDone   <= 1'b0;
      running    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_phase    <= w_phase_next;
      r_step_d   <= step;
      r_single   <= w_single_next;
      stateFetch <= (w_state_next == ST_FETCH);
      stateDefer <= (w_state_next == ST_DEFER);
      stateExec  <= (w_state_next == ST_EXEC);
      ckFetch    <= (w_state_next == ST_FETCH) && (w_phase_next == STROBE_PHASE);
      ckDefer    <= (w_state_next == ST_DEFER) && (w_phase_next == STROBE_PHASE);
      ckExec     <= (w_state_next == ST_EXEC)  && (w_phase_next == STROBE_PHASE);
      instDone   <= w_complete;
      running    <= (w_state_next != ST_HALT);
    end
  end

endmodule
